// File: rtl/music_box_state_make_recording.sv
// Record state: run-length encodes noteInput per ms tick into {note, duration} RAM words.
// Optional MUSICBOX_RECORD_SILENCE_TRIM_EN drops leading and trailing silence runs.
module music_box_state_make_recording #(
  parameter int STATE_CODE = 2,
  parameter int MAX_MS     = 5000,
  parameter int ADDR_W     = 8
) (
  input  logic              clock_50Mhz,
  input  logic              reset_n,
  input  logic              tick_1Khz,
  input  logic [4:0]        currentState,
  input  logic [4:0]        noteInput,
  output logic              memWriteEnable,
  output logic [ADDR_W-1:0] memAddress,
  output logic [15:0]       memWriteData,
  output logic [ADDR_W:0]   recordingLength,
  output logic              stateComplete,
  output logic [31:0]       debugString
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REC   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [10:0]     RUN_MAX = 11'd2047;

  logic [1:0]        r_state;
  logic [4:0]        r_curNote;
  logic [10:0]       r_runLen;
  logic [15:0]       r_elapsed;
  logic [ADDR_W:0]   r_wIdx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;
  logic              r_done;

  logic              w_match;
  logic              w_same;
  logic              w_keep;
  logic              w_flushKeep;
  logic              w_emit;
  logic              w_wrRec;
  logic              w_wrFl;
  logic              w_wr;
  logic              w_full;
  logic              w_last;
  logic [ADDR_W:0]   w_nextIdx;
  logic [15:0]       w_word;

  assign w_match   = currentState == 5'(STATE_CODE);
  assign w_same    = (noteInput == r_curNote) && (r_runLen != RUN_MAX);
  assign w_word    = {r_curNote, r_runLen};
  assign w_nextIdx = r_wIdx + 1'b1;
  assign w_full    = w_nextIdx == DEPTH;
  assign w_last    = (r_elapsed + 16'd1) == 16'(MAX_MS);

`ifdef MUSICBOX_RECORD_SILENCE_TRIM_EN
  logic r_wroteNz;

  // Remember whether any audible note has reached the RAM yet
  always_ff @(posedge clock_50Mhz) begin
    if (!reset_n) begin
      r_wroteNz <= 1'b0;
    end else if (r_state == S_IDLE && w_match) begin
      r_wroteNz <= 1'b0;
    end else if (w_wr && r_curNote != 5'd0) begin
      r_wroteNz <= 1'b1;
    end
  end

  assign w_keep      = r_wroteNz || (r_curNote != 5'd0);
  assign w_flushKeep = r_curNote != 5'd0;
`else
  assign w_keep      = 1'b1;
  assign w_flushKeep = 1'b1;
`endif

  assign w_emit  = !w_same && (r_runLen != 11'd0) && w_keep;
  assign w_wrRec = (r_state == S_REC) && w_match && tick_1Khz && w_emit;
  assign w_wrFl  = (r_state == S_FLUSH) && w_match
                && (r_runLen != 11'd0) && w_flushKeep;
  assign w_wr    = w_wrRec || w_wrFl;

  // Sequencer: run-length tracking, window timing and write index
  always_ff @(posedge clock_50Mhz) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_curNote <= 5'd0;
      r_runLen  <= 11'd0;
      r_elapsed <= 16'd0;
      r_wIdx    <= '0;
    end else begin
      if (w_wr) r_wIdx <= w_nextIdx;
      unique case (r_state)
        S_IDLE: begin
          if (w_match) begin
            r_state   <= S_REC;
            r_curNote <= 5'd0;
            r_runLen  <= 11'd0;
            r_elapsed <= 16'd0;
            r_wIdx    <= '0;
          end
        end
        S_REC: begin
          if (!w_match) begin
            r_state <= S_IDLE;
          end else if (tick_1Khz) begin
            r_elapsed <= r_elapsed + 16'd1;
            if (w_same) begin
              r_runLen <= r_runLen + 11'd1;
            end else begin
              r_curNote <= noteInput;
              r_runLen  <= 11'd1;
            end
            if (w_wrRec && w_full) r_state <= S_DONE;
            else if (w_last)       r_state <= S_FLUSH;
          end
        end
        S_FLUSH: r_state <= w_match ? S_DONE : S_IDLE;
        S_DONE: if (!w_match) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered RAM port and completion flag
  always_ff @(posedge clock_50Mhz) begin
    if (!reset_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= 16'd0;
      r_done <= 1'b0;
    end else begin
      r_we   <= w_wr;
      r_done <= (r_state == S_DONE) && w_match;
      if (w_wr) begin
        r_addr <= r_wIdx[ADDR_W-1:0];
        r_data <= w_word;
      end
    end
  end

  assign memWriteEnable  = r_we;
  assign memAddress      = r_addr;
  assign memWriteData    = r_data;
  assign recordingLength = r_wIdx;
  assign stateComplete   = r_done;
  assign debugString     = {r_elapsed, 16'(r_wIdx)};

endmodule

// File: tb/tb_music_box_state_make_recording.sv
// Bench for music_box_state_make_recording: directed + random note streams
// checked against a run-length model built from the recording rules.
module tb_music_box_state_make_recording;

`ifdef MUSICBOX_RECORD_SILENCE_TRIM_EN
  localparam bit TRIM = 1'b1;
`else
  localparam bit TRIM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic [4:0]  cs = 5'd0;
  logic [4:0]  cs2 = 5'd0;
  logic [4:0]  note = 5'd0;

  logic        we, sc;
  logic [7:0]  addr;
  logic [15:0] data;
  logic [8:0]  len;
  logic [31:0] dbg;

  logic        we2, sc2;
  logic [2:0]  addr2;
  logic [15:0] data2;
  logic [3:0]  len2;
  logic [31:0] dbg2;

  music_box_state_make_recording u_dut (
    .clock_50Mhz     (clk),
    .reset_n         (reset_n),
    .tick_1Khz       (tick),
    .currentState    (cs),
    .noteInput       (note),
    .memWriteEnable  (we),
    .memAddress      (addr),
    .memWriteData    (data),
    .recordingLength (len),
    .stateComplete   (sc),
    .debugString     (dbg)
  );

  music_box_state_make_recording #(.ADDR_W(3)) u_small (
    .clock_50Mhz     (clk),
    .reset_n         (reset_n),
    .tick_1Khz       (tick),
    .currentState    (cs2),
    .noteInput       (note),
    .memWriteEnable  (we2),
    .memAddress      (addr2),
    .memWriteData    (data2),
    .recordingLength (len2),
    .stateComplete   (sc2),
    .debugString     (dbg2)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          passed = 0;
  int          failed = 0;
  logic [31:0] wq[$];
  logic [31:0] wq2[$];
  int          notes[$];
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (we)  wq.push_back({16'(addr), data});
    if (we2) wq2.push_back({16'(addr2), data2});
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic [4:0] n);
    note = n;
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
  endtask

  // Plain RLE of the tick stream, runs split into 2047 ms chunks,
  // optional silence trimming, then truncation to RAM depth.
  task automatic build_exp(input int depth);
    int rn[$];
    int rl[$];
    int cn[$];
    int cl[$];
    int l;
    exp_q.delete();
    foreach (notes[i]) begin
      if (rn.size() != 0 && rn[rn.size()-1] == notes[i])
        rl[rl.size()-1] += 1;
      else begin
        rn.push_back(notes[i]);
        rl.push_back(1);
      end
    end
    foreach (rn[i]) begin
      l = rl[i];
      while (l > 2047) begin
        cn.push_back(rn[i]);
        cl.push_back(2047);
        l -= 2047;
      end
      cn.push_back(rn[i]);
      cl.push_back(l);
    end
    if (TRIM) begin
      while (cn.size() != 0 && cn[0] == 0) begin
        void'(cn.pop_front());
        void'(cl.pop_front());
      end
      if (cn.size() != 0 && cn[cn.size()-1] == 0) begin
        void'(cn.pop_back());
        void'(cl.pop_back());
      end
    end
    foreach (cn[i])
      if (i < depth) exp_q.push_back(16'((cn[i] << 11) | cl[i]));
  endtask

  task automatic cmp_q(input string tag);
    int n;
    chk({tag, "_count"}, 32'(wq.size()), 32'(exp_q.size()));
    n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_word"}, {16'd0, wq[i][15:0]}, {16'd0, exp_q[i]});
      chk({tag, "_addr"}, {16'd0, wq[i][31:16]}, 32'(i));
    end
  endtask

  task automatic gen_rand(input int n);
    int v;
    int l;
    notes.delete();
    while (notes.size() < n) begin
      v = $urandom_range(0, 4);
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(1500, 3000)
                                       : $urandom_range(1, 60);
      repeat (l) if (notes.size() < n) notes.push_back(v);
    end
  endtask

  task automatic run_rec();
    foreach (notes[i]) do_tick(5'(notes[i]));
    cyc(3);
  endtask

  initial begin
    int n0;

    // reset state
    cyc(2);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_len", 32'(len), 32'd0);
    chk("rst_sc", 32'(sc), 32'd0);
    chk("rst_dbg", dbg, 32'd0);
    reset_n = 1'b1;
    cyc(1);

    // full window, mixed notes
    notes.delete();
    repeat (300) notes.push_back(5);
    repeat (4700) notes.push_back(0);
    wq.delete();
    cs = 5'd2;
    cyc(1);
    for (int i = 0; i < 4999; i++) do_tick(5'(notes[i]));
    note = 5'd0;
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("t1_sc_t1", 32'(sc), 32'd0);
    cyc(1);
    chk("t1_flush_we", 32'(we), TRIM ? 32'd0 : 32'd1);
    chk("t1_sc_t2", 32'(sc), 32'd0);
    cyc(1);
    chk("t1_sc_t3", 32'(sc), 32'd1);
    chk("t1_we_t3", 32'(we), 32'd0);
    build_exp(256);
    cmp_q("t1");
    chk("t1_len", 32'(len), 32'(exp_q.size()));
    chk("t1_dbg", dbg, {16'd5000, 16'(exp_q.size())});
    if (!TRIM) begin
      chk("t1_w0", wq[0], {16'd0, 16'h292C});
      chk("t1_w1", wq[1], {16'd1, 16'h07FF});
      chk("t1_w2", wq[2], {16'd2, 16'h07FF});
      chk("t1_w3", wq[3], {16'd3, 16'h025E});
      chk("t1_dbg_k", dbg, 32'h13880004);
    end

    // hold in DONE, then release
    n0 = wq.size();
    repeat (10) do_tick(5'($urandom_range(0, 31)));
    chk("hold_sc", 32'(sc), 32'd1);
    chk("hold_nowr", 32'(wq.size()), 32'(n0));
    cs = 5'd0;
    cyc(1);
    chk("rel_sc", 32'(sc), 32'd0);
    cyc(1);

    // early full on the 8-entry instance
    wq2.delete();
    cs2 = 5'd2;
    cyc(1);
    for (int k = 1; k <= 9; k++) do_tick(5'(k));
    chk("full_cnt9", 32'(wq2.size()), 32'd8);
    chk("full_last", wq2[7], {16'd7, 16'h4001});
    chk("full_sc", 32'(sc2), 32'd1);
    chk("full_len", 32'(len2), 32'd8);
    do_tick(5'd10);
    do_tick(5'd11);
    chk("full_nomore", 32'(wq2.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk("full_word", wq2[i], {16'(i), 16'(((i + 1) << 11) | 1)});
    cs2 = 5'd0;
    cyc(2);

    // abort with an open run, then re-enter
    wq.delete();
    cs = 5'd2;
    cyc(1);
    repeat (100) do_tick(5'd3);
    cs = 5'd0;
    cyc(3);
    chk("abort_nowr", 32'(wq.size()), 32'd0);
    chk("abort_sc", 32'(sc), 32'd0);
    chk("abort_len", 32'(len), 32'd0);
    cs = 5'd2;
    cyc(1);
    do_tick(5'd4);
    do_tick(5'd6);
    chk("reent_cnt", 32'(wq.size()), 32'd1);
    chk("reent_w0", wq[0], {16'd0, 16'h2001});
    cs = 5'd0;
    cyc(2);
    chk("reent_len", 32'(len), 32'd1);

    // reset mid-record, then a full random recording
    cs = 5'd2;
    cyc(1);
    gen_rand(1999);
    foreach (notes[i]) do_tick(5'(notes[i]));
    tick = 1'b1;
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    tick = 1'b0;
    chk("mrst_we", 32'(we), 32'd0);
    chk("mrst_addr", 32'(addr), 32'd0);
    chk("mrst_data", 32'(data), 32'd0);
    chk("mrst_len", 32'(len), 32'd0);
    chk("mrst_sc", 32'(sc), 32'd0);
    chk("mrst_dbg", dbg, 32'd0);
    cyc(1);
    wq.delete();
    gen_rand(5000);
    run_rec();
    build_exp(256);
    cmp_q("mrst_rec");
    chk("mrst_rec_sc", 32'(sc), 32'd1);
    chk("mrst_rec_len", 32'(len), 32'(exp_q.size()));
    chk("mrst_rec_dbg", dbg, {16'd5000, 16'(exp_q.size())});
    cs = 5'd0;
    cyc(2);

    // leading silence
    notes.delete();
    repeat (200) notes.push_back(0);
    repeat (4800) notes.push_back(7);
    wq.delete();
    cs = 5'd2;
    cyc(1);
    run_rec();
    build_exp(256);
    cmp_q("trim");
    if (TRIM) begin
      chk("trim_len", 32'(len), 32'd3);
      chk("trim_w0", {16'd0, wq[0][15:0]}, 32'h3FFF);
      chk("trim_w2", {16'd0, wq[2][15:0]}, 32'h3AC2);
    end else begin
      chk("trim_len", 32'(len), 32'd4);
      chk("trim_w0", {16'd0, wq[0][15:0]}, 32'h00C8);
      chk("trim_w3", {16'd0, wq[3][15:0]}, 32'h3AC2);
    end
    chk("trim_sc", 32'(sc), 32'd1);
    cs = 5'd0;
    cyc(2);

    // one more random full window
    wq.delete();
    cs = 5'd2;
    cyc(1);
    gen_rand(5000);
    run_rec();
    build_exp(256);
    cmp_q("rand");
    chk("rand_sc", 32'(sc), 32'd1);
    chk("rand_len", 32'(len), 32'(exp_q.size()));
    cs = 5'd0;
    cyc(2);
    chk("rand_rel", 32'(sc), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/music_box_state_make_recording.md
# music_box_state_make_recording

Recording-state controller for the music box: the writer counterpart to the playback state. While the state controller holds `currentState` at the record code, samples the player's note input once per millisecond, run-length encodes it into `{note, duration}` words, and writes them to the recording RAM. It signals completion to the state controller after a fixed recording window or when the RAM fills.

## Interface
- `STATE_CODE`, 2: `currentState` value that selects this state.
- `MAX_MS`, 5000: recording window in 1 kHz ticks.
- `ADDR_W`, 8: RAM address width; depth = 2^ADDR_W entries. ADDR_W ≤ 15.

- `clock_50Mhz` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `tick_1Khz` in 1: single-cycle strobe, once per ms, synchronous to `clock_50Mhz`.
- `currentState` in 5: state code from the state controller.
- `noteInput` in 5: current note; 0 = silence.
- `memWriteEnable` out 1: one-cycle RAM write strobe.
- `memAddress` out ADDR_W: RAM write address.
- `memWriteData` out 16: `{note[4:0], duration[10:0]}`, duration in ms.
- `recordingLength` out ADDR_W+1: entries written this recording.
- `stateComplete` out 1: recording finished; the state controller may return to DoNothing.
- `debugString` out 32: `{elapsed[15:0], zero-extended recordingLength[15:0]}`.

## Operation
- Internal registers:
  - `curNote` (5 bits)
  - `runLen` (11 bits, saturates at 2047)
  - `elapsed` (16 bits)
  - write index `wIdx` (ADDR_W+1 bits)
- States: IDLE, RECORD, FLUSH, DONE.
- **IDLE**
  - Outputs idle; `recordingLength` holds its last value.
  - When `currentState == STATE_CODE`: go to RECORD and clear `curNote`, `runLen`, `elapsed`, `wIdx` and `recordingLength`.
- **RECORD**, on each `tick_1Khz`:
  - `elapsed++`.
  - If `noteInput == curNote` and `runLen < 2047`: `runLen++`.
  - Otherwise, when `runLen != 0`, emit `{curNote, runLen}`; then set `curNote <= noteInput` and `runLen <= 1`.
- **Emit**
  - Registered. On the cycle after the tick: `memWriteEnable = 1`, `memAddress = wIdx`, `memWriteData` = word.
  - The same cycle sets `wIdx` and `recordingLength` to `wIdx + 1`.
- **Full**
  - When an emit makes `wIdx == 2^ADDR_W`, go to DONE.
  - No further writes occur.
- **End of window**
  - The tick that makes `elapsed == MAX_MS` is processed normally and moves the block to FLUSH.
  - FLUSH writes the final run (if `runLen != 0` and the RAM is not full) one cycle after any emit from that tick, then goes to DONE.
- **DONE**
  - `stateComplete = 1`; it is held until `currentState != STATE_CODE`, then the block returns to IDLE.
- **Abort**
  - If `currentState != STATE_CODE` in RECORD or FLUSH, go to IDLE the next cycle.
  - No pending write is issued; `recordingLength` keeps the entries written so far.
- Ticks arriving in FLUSH, DONE or IDLE are ignored.

## Timing
- Reset (`reset_n = 0` at a clock edge) forces IDLE. All outputs go to 0: `memWriteEnable`, `memAddress`, `memWriteData`, `recordingLength`, `stateComplete` and `debugString`. Reset mid-recording discards the run in progress.
- Write latency is 1 cycle after the tick; the FLUSH write follows at tick + 2 cycles; `stateComplete` rises at tick + 3 cycles.
- `memWriteEnable` is never high for two consecutive cycles except tick-emit followed by the flush write.
- If `currentState` matches on the same cycle as a tick while in IDLE, the tick is ignored; RECORD starts on the next cycle.
- `elapsed` never exceeds MAX_MS. Durations in written words always sum to `elapsed` unless trimming applies or the RAM filled.

## Configuration
- `MUSICBOX_RECORD_SILENCE_TRIM_EN`
  - Defined:
    - Runs with `curNote == 0` are not written while no nonzero note has yet been written (leading silence).
    - The final flush run is dropped if its note is 0 (trailing silence).
    - `elapsed` still counts every tick.
  - Undefined: all runs are written, including silence.

## Test plan
- **Full window, mixed notes:** trim off; `noteInput = 5` for 300 ticks then 0 for 4700.
  - Writes: addr0 `{5,300}`, addr1 `{0,2047}`, addr2 `{0,2047}`, addr3 `{0,606}`.
  - Then `stateComplete` = 1, `recordingLength` = 4, `debugString` = `0x13880004`.
- **Early full, ADDR_W=3:** `noteInput` changes every tick (1, 2, 3, ...).
  - The 8th write (addr7, `{8,1}`) occurs on tick 9.
  - DONE and `stateComplete` = 1 with `recordingLength` = 8; no further `memWriteEnable`.
- **Abort:** `currentState` leaves STATE_CODE after tick 100 with note 3 held.
  - No write of the open run; `stateComplete` stays 0; `recordingLength` = 0.
  - Re-entering restarts at addr0.
- **Reset mid-record:** `reset_n = 0` for one cycle at tick 2000.
  - All outputs 0 next cycle.
  - With `currentState` still at STATE_CODE, recording restarts and completes 5000 ticks later.
- **Trim:** `noteInput = 0` for 200 ticks then 7 for 4800.
  - With the macro: writes `{7,2047}`, `{7,2047}`, `{7,706}`, `recordingLength` = 3.
  - Without the macro: a leading `{0,200}` is written first, `recordingLength` = 4.
- **Hold/release:** in DONE, `currentState` stays at STATE_CODE for 10 ticks.
  - `stateComplete` stays 1 and no writes occur.
  - On `currentState` = 0, `stateComplete` = 0 the next cycle.
